// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
//   Request/response bundle between the pipeline memory stage (master) and the
//   multi-cycle data memory (slave).
//
//   req_en      master->slave  request valid (load or store)
//   req_wr      master->slave  1 = store, 0 = load
//   addr[15:0]  master->slave  byte address
//   wdata[15:0] master->slave  store data
//   rdata[15:0] slave->master  load data, valid with data_valid
//   data_valid  slave->master  one-cycle response strobe
//   stall       slave->master  pipeline hold request
//   err         slave->master  misaligned-access flag, only present when
//                              DMEM_ALIGN_CHECK_EN is defined
// -----------------------------------------------------------------------------
interface data_mem_responder_if;
  logic        req_en;
  logic        req_wr;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        data_valid;
  logic        stall;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        err;

  modport master (output req_en, req_wr, addr, wdata,
                  input  rdata, data_valid, stall, err);
  modport slave  (input  req_en, req_wr, addr, wdata,
                  output rdata, data_valid, stall, err);
`else
  modport master (output req_en, req_wr, addr, wdata,
                  input  rdata, data_valid, stall);
  modport slave  (input  req_en, req_wr, addr, wdata,
                  output rdata, data_valid, stall);
`endif
endinterface

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Multi-cycle 16-bit data memory answering one load/store at a time from the
//   pipeline memory stage. `stall` is held for LATENCY cycles per access, then
//   a one-cycle `data_valid` strobe returns load data.
//
//   Parameters
//     ADDR_W   word-address bits (depth = 2**ADDR_W words)
//     LATENCY  cycles `stall` is held per access, 1..15
//
//   Ports
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    data_mem_responder_if.slave (req_en, req_wr, addr, wdata in;
//            rdata, data_valid, stall [, err] out)
//
//   Optional build macro: DMEM_ALIGN_CHECK_EN
//     When defined, requests with addr[0] = 1 are flagged on `err` together
//     with `data_valid`; misaligned stores do not write and misaligned loads
//     return 16'h0000. When undefined, addr[0] is simply ignored.
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                wr_q, wr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                data_valid_q;
  logic [15:0]         rdata_q;
  logic                enter_resp;
  logic                acc_mis;
  logic                commit_wr;
  logic                commit_rd;

  logic [15:0]         mem [0:(1<<ADDR_W)-1];

  // Only part of the address is decoded; upper bits alias.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^bus.addr;

`ifdef DMEM_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  logic err_q;
`endif

  // Next-state and request capture. The _d copies of the captured fields are
  // what the commit uses, so with LATENCY = 1 (commit on the accept edge) the
  // live inputs flow straight through, and otherwise the held values do.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_en) begin
          idx_d   = bus.addr[ADDR_W:1];
          wr_d    = bus.req_wr;
          wdata_d = bus.wdata;
`ifdef DMEM_ALIGN_CHECK_EN
          mis_d   = bus.addr[0];
`endif
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = 4'(cnt_q - 4'd1);
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        // A request seen here belongs to the instruction now finishing.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_mis = mis_d;
`else
  assign acc_mis = 1'b0;
`endif

  // RESP is only ever reached from IDLE or WAIT, so this is the entry edge.
  assign enter_resp = (state_d == RESP);
  assign commit_wr  = enter_resp && wr_d && !acc_mis;
  assign commit_rd  = enter_resp && !wr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      idx_q        <= '0;
      wr_q         <= 1'b0;
      wdata_q      <= 16'h0000;
      data_valid_q <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      mis_q        <= 1'b0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      data_valid_q <= enter_resp;
`ifdef DMEM_ALIGN_CHECK_EN
      mis_q        <= mis_d;
      err_q        <= enter_resp && mis_d;
`endif
    end
  end

  // Storage: write port kept free of reset so it maps onto block RAM. A reset
  // on the commit edge drops the store.
  always_ff @(posedge clk) begin
    if (rst_n && commit_wr) begin
      mem[idx_d] <= wdata_d;
    end
  end

  // Registered read port; holds its value across stores.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= 16'h0000;
    end else if (commit_rd) begin
      rdata_q <= acc_mis ? 16'h0000 : mem[idx_d];
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.data_valid = data_valid_q;
  assign bus.stall      = (state_q == IDLE && bus.req_en) || (state_q == WAIT);
`ifdef DMEM_ALIGN_CHECK_EN
  assign bus.err        = err_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Two responders side by side: instance 0 with LATENCY = 4, instance 1 with
//   LATENCY = 1, both ADDR_W = 10. Expected responses come from a word model
//   and are queued when a request is driven, then popped at data_valid.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if if_a ();
  data_mem_responder_if if_b ();

  data_mem_responder #(.ADDR_W(10), .LATENCY(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  data_mem_responder #(.ADDR_W(10), .LATENCY(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  typedef struct {
    int          sel;
    bit          is_load;
    logic [15:0] data;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [int];
  logic [15:0] last_rd [2];
  int          checks = 0;
  int          errors = 0;

  function automatic int lat_of(int sel);
    return (sel == 0) ? 4 : 1;
  endfunction

  task automatic drive(int sel, bit en, bit wr, logic [15:0] a, logic [15:0] d);
    if (sel == 0) begin
      if_a.req_en = en; if_a.req_wr = wr; if_a.addr = a; if_a.wdata = d;
    end else begin
      if_b.req_en = en; if_b.req_wr = wr; if_b.addr = a; if_b.wdata = d;
    end
  endtask

  function automatic logic get_stall(int sel);
    return (sel == 0) ? if_a.stall : if_b.stall;
  endfunction

  function automatic logic get_dv(int sel);
    return (sel == 0) ? if_a.data_valid : if_b.data_valid;
  endfunction

  function automatic logic [15:0] get_rd(int sel);
    return (sel == 0) ? if_a.rdata : if_b.rdata;
  endfunction

  function automatic logic get_err(int sel);
`ifdef DMEM_ALIGN_CHECK_EN
    return (sel == 0) ? if_a.err : if_b.err;
`else
    return (sel == 0) ? 1'b0 : 1'b0;
`endif
  endfunction

  // Expected response for an accepted request; updates the word model.
  function automatic void push_exp(int sel, bit wr, logic [15:0] a, logic [15:0] d);
    exp_t e;
    int   key;
    bit   mis;
    key = sel * 65536 + int'(a[10:1]);
    mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis = a[0];
`endif
    e.sel     = sel;
    e.is_load = !wr;
    e.err     = mis;
    if (wr) begin
      if (!mis) model[key] = d;
      e.data = last_rd[sel];
    end else begin
      e.data = mis ? 16'h0000 : model[key];
      last_rd[sel] = e.data;
    end
    sb.push_back(e);
  endfunction

  // Issue one request and observe the following 12 cycles.
  task automatic access(int sel, bit wr, logic [15:0] a, logic [15:0] d,
                        output logic [15:0] rd, output int lat, output int stalls,
                        output int dvs, output logic err_seen);
    lat = -1; stalls = 0; dvs = 0; rd = 'x; err_seen = 1'b0;
    @(posedge clk); #1;
    drive(sel, 1'b1, wr, a, d);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (get_stall(sel)) stalls++;
      if (get_dv(sel)) begin
        dvs++;
        if (lat < 0) begin
          lat = c; rd = get_rd(sel); err_seen = get_err(sel);
        end
      end
      @(posedge clk); #1;
      // Garbage on the inputs after acceptance must not matter.
      drive(sel, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    end
    $display("txn inst=%0d %s addr=%h wdata=%h rdata=%h lat=%0d stalls=%0d",
             sel, wr ? "ST" : "LD", a, d, rd, lat, stalls);
  endtask

  task automatic test_reset();
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        checks++;
        if (get_rd(s) !== 16'h0000) begin
          errors++; $display("FAIL reset_rdata inst=%0d got %h want 0000", s, get_rd(s));
        end
        checks++;
        if (get_dv(s) !== 1'b0) begin
          errors++; $display("FAIL reset_dv inst=%0d got %b want 0", s, get_dv(s));
        end
        checks++;
        if (get_stall(s) !== 1'b0) begin
          errors++; $display("FAIL reset_stall inst=%0d got %b want 0", s, get_stall(s));
        end
      end
    end
  endtask

  // Generic table runner body shared by the access-style tests is kept inline
  // in each test so each scenario reads on its own.
  task automatic test_store_load();
    logic [15:0] rd; int lat, st, dvs; logic es; exp_t e;
    bit          wr_t [3]   = '{1'b1, 1'b1, 1'b0};
    logic [15:0] a_t  [3]   = '{16'h0010, 16'h0012, 16'h0010};
    logic [15:0] d_t  [3]   = '{16'h1234, 16'h9876, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      push_exp(0, wr_t[i], a_t[i], d_t[i]);
      access(0, wr_t[i], a_t[i], d_t[i], rd, lat, st, dvs, es);
      e = sb.pop_front();
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL store_load_lat got %0d want 4", lat); end
      checks++;
      if (st !== 4) begin errors++; $display("FAIL store_load_stalls got %0d want 4", st); end
      checks++;
      if (dvs !== 1) begin errors++; $display("FAIL store_load_dv_count got %0d want 1", dvs); end
      checks++;
      if (rd !== e.data) begin errors++; $display("FAIL store_load_rdata got %h want %h", rd, e.data); end
    end
  endtask

  task automatic test_latency_one();
    logic [15:0] rd; int lat, st, dvs; logic es; exp_t e;
    bit          wr_t [2] = '{1'b1, 1'b0};
    logic [15:0] d_t  [2] = '{16'hBEEF, 16'h0000};
    for (int i = 0; i < 2; i++) begin
      push_exp(1, wr_t[i], 16'h0002, d_t[i]);
      access(1, wr_t[i], 16'h0002, d_t[i], rd, lat, st, dvs, es);
      e = sb.pop_front();
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL lat1_lat got %0d want 1", lat); end
      checks++;
      if (st !== 1) begin errors++; $display("FAIL lat1_stalls got %0d want 1", st); end
      checks++;
      if (dvs !== 1) begin errors++; $display("FAIL lat1_dv_count got %0d want 1", dvs); end
      checks++;
      if (rd !== e.data) begin errors++; $display("FAIL lat1_rdata got %h want %h", rd, e.data); end
    end
  endtask

  task automatic test_aliasing();
    logic [15:0] rd; int lat, st, dvs; logic es; exp_t e;
    bit          wr_t [2] = '{1'b1, 1'b0};
    logic [15:0] a_t  [2] = '{16'h0004, 16'h0804};
    for (int i = 0; i < 2; i++) begin
      push_exp(0, wr_t[i], a_t[i], 16'hA5A5);
      access(0, wr_t[i], a_t[i], 16'hA5A5, rd, lat, st, dvs, es);
      e = sb.pop_front();
      checks++;
      if (rd !== e.data) begin errors++; $display("FAIL alias_rdata got %h want %h", rd, e.data); end
    end
    checks++;
    if (rd !== 16'hA5A5) begin errors++; $display("FAIL alias_value got %h want a5a5", rd); end
  endtask

  // LATENCY = 1 with req_en held high: accept, RESP (ignored), accept, RESP.
  task automatic test_back_to_back();
    bit          en_t  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit          wr_t  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] a_t   [5] = '{16'h0006, 16'h0006, 16'h0006, 16'h0008, 16'h0000};
    logic [15:0] d_t   [5] = '{16'hC3C3, 16'h1111, 16'h2222, 16'h3333, 16'h0000};
    bit          acc_t [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bit          st_t  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bit          dv_t  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_t e;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      #1 drive(1, en_t[c], wr_t[c], a_t[c], d_t[c]);
      if (acc_t[c]) push_exp(1, wr_t[c], a_t[c], d_t[c]);
      @(negedge clk);
      checks++;
      if (get_stall(1) !== st_t[c]) begin
        errors++; $display("FAIL b2b_stall cyc=%0d got %b want %b", c, get_stall(1), st_t[c]);
      end
      checks++;
      if (get_dv(1) !== dv_t[c]) begin
        errors++; $display("FAIL b2b_dv cyc=%0d got %b want %b", c, get_dv(1), dv_t[c]);
      end
      if (get_dv(1) === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (get_rd(1) !== e.data) begin
          errors++; $display("FAIL b2b_rdata cyc=%0d got %h want %h", c, get_rd(1), e.data);
        end
        $display("txn inst=1 b2b cyc=%0d rdata=%h", c, get_rd(1));
      end
      @(posedge clk);
    end
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL b2b_scoreboard left=%0d want 0", sb.size()); end
    sb.delete();
    #1 drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] rd; int lat, st, dvs; logic es; exp_t e;
    int dv_seen;
    push_exp(0, 1'b1, 16'h0020, 16'h1111);
    access(0, 1'b1, 16'h0020, 16'h1111, rd, lat, st, dvs, es);
    e = sb.pop_front();
    // Store 0x5555, then reset during WAIT cycle 2.
    @(posedge clk); #1 drive(0, 1'b1, 1'b1, 16'h0020, 16'h5555);
    @(posedge clk); #1 drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    dv_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (get_dv(0)) dv_seen++;
    end
    checks++;
    if (dv_seen !== 0) begin errors++; $display("FAIL abort_dv got %0d pulses want 0", dv_seen); end
    checks++;
    if (get_rd(0) !== 16'h0000) begin errors++; $display("FAIL abort_rdata got %h want 0000", get_rd(0)); end
    $display("txn inst=0 ST addr=0020 wdata=5555 aborted by reset");
    push_exp(0, 1'b0, 16'h0020, 16'h0000);
    access(0, 1'b0, 16'h0020, 16'h0000, rd, lat, st, dvs, es);
    e = sb.pop_front();
    checks++;
    if (rd !== e.data) begin errors++; $display("FAIL abort_load got %h want %h", rd, e.data); end
    checks++;
    if (rd !== 16'h1111) begin errors++; $display("FAIL abort_value got %h want 1111", rd); end
  endtask

`ifdef DMEM_ALIGN_CHECK_EN
  task automatic test_align();
    logic [15:0] rd; int lat, st, dvs; logic es; exp_t e;
    bit          wr_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] a_t  [4] = '{16'h0030, 16'h0031, 16'h0030, 16'h0031};
    logic [15:0] d_t  [4] = '{16'h1111, 16'h7777, 16'h0000, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      push_exp(0, wr_t[i], a_t[i], d_t[i]);
      access(0, wr_t[i], a_t[i], d_t[i], rd, lat, st, dvs, es);
      e = sb.pop_front();
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL align_lat got %0d want 4", lat); end
      checks++;
      if (es !== e.err) begin errors++; $display("FAIL align_err got %b want %b", es, e.err); end
      checks++;
      if (rd !== e.data) begin errors++; $display("FAIL align_rdata got %h want %h", rd, e.data); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_store_load();
    test_latency_one();
    test_aliasing();
    test_back_to_back();
    test_reset_mid_op();
`ifdef DMEM_ALIGN_CHECK_EN
    test_align();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data memory that answers load/store requests from the pipeline's memory stage.
- Holds one request at a time. Raises `stall` while the access is in progress, then returns read data with a one-cycle `data_valid` strobe.
- Replaces the zero-latency data memory model so the pipeline's stall path gets exercised.
- Sits between the memory stage and the mem/writeback pipeline register.

Parameters:
- ADDR_W, 10, number of word-address bits (memory depth = 2^ADDR_W 16-bit words).
- LATENCY, 4, total cycles `stall` is held per access; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_en  input  1  request valid (memory stage `mem_read | mem_write`).
- req_wr  input  1  1 = store, 0 = load; sampled only with `req_en`.
- addr  input  16  byte address; word index = `addr[ADDR_W:1]`.
- wdata  input  16  store data; sampled only with `req_en && req_wr`.
- rdata  output  16  load data; valid when `data_valid = 1`.
- data_valid  output  1  one-cycle response strobe.
- stall  output  1  pipeline hold request (combinational).

Behaviour:
- Reset: `rst_n = 0` at a rising edge sets state = IDLE, counter = 0, `rdata = 16'h0000`, `data_valid = 0`. The storage array is not cleared.
- States:
  - IDLE: no access in progress.
  - WAIT: access in progress.
  - RESP: response cycle.
- IDLE with `req_en = 1`:
  - Capture `addr`, `req_wr`, `wdata` into internal registers; load counter with LATENCY-1.
  - Next state = RESP if LATENCY = 1, else WAIT.
- WAIT: counter decrements each cycle. When counter = 1 at an edge, next state = RESP.
- Commit on the edge entering RESP:
  - Store: write captured `wdata` to `mem[captured index]`; `rdata` holds its previous value.
  - Load: register `mem[captured index]` into `rdata`.
- RESP:
  - `data_valid = 1`, `stall = 0`.
  - Next state is always IDLE.
  - `req_en` in RESP is ignored; it is still the finishing instruction's request.
- Stall timing:
  - `stall = (state == IDLE && req_en) || state == WAIT`.
  - Request cycle = cycle 0; cycles 1..LATENCY-1 = WAIT; cycle LATENCY = RESP.
  - `stall` is therefore high for exactly LATENCY consecutive cycles per access.
- `data_valid` is registered and high for exactly one cycle per accepted request.
- Back-to-back requests: a new request is accepted in the IDLE cycle after RESP. Minimum spacing = LATENCY+1 cycles.
- Inputs are sampled only at acceptance; changes to `addr`, `wdata`, `req_wr` during WAIT have no effect.
- Address aliasing: `addr[15:ADDR_W+1]` is ignored, so addresses wrap modulo 2^(ADDR_W+1) bytes.
- `addr[0]` is ignored unless the optional feature is enabled.
- Reset mid-operation: the access aborts. A store not yet committed (state WAIT or the IDLE request cycle) is dropped and memory is unchanged. `data_valid` is not asserted for the aborted request.
- Read of a never-written word returns X in simulation; the bench must write before reading.

Optional Feature:
- Macro: `DMEM_ALIGN_CHECK_EN`.
- Defined:
  - Adds output port `err` (1 bit); reset value 0.
  - A request with `addr[0] = 1` still takes the full LATENCY and produces `data_valid`.
  - A misaligned store is suppressed (no array write).
  - A misaligned load returns `rdata = 16'h0000`.
  - `err = 1` in the same cycle as `data_valid`, 0 otherwise.
- Not defined: no `err` port; `addr[0]` is ignored and the access proceeds on the word index.

Test Plan:
- Reset then idle: `rst_n` low 2 cycles, `req_en = 0` -> `rdata = 0000`, `data_valid = 0`, `stall = 0` for 10 cycles.
- Store then load, LATENCY = 4:
  - Store `0x1234` to `addr = 0x0010` -> `stall` high cycles 0..3, `data_valid` pulse at cycle 4.
  - Load `0x0010` in the next IDLE cycle -> `rdata = 0x1234` with `data_valid` 4 cycles after its request cycle.
- LATENCY = 1: store `0xBEEF` to `0x0002`, then load `0x0002` -> `stall` high 1 cycle each, `rdata = 0xBEEF`, loads/stores spaced 2 cycles.
- Aliasing, ADDR_W = 10: store `0xA5A5` to `0x0004`, load `0x0804` -> `rdata = 0xA5A5`.
- Reset mid-op: store `0x5555` to `0x0020` (prior contents `0x1111`), pull `rst_n` low in WAIT cycle 2 -> no `data_valid`; later load `0x0020` returns `0x1111`.
- With `DMEM_ALIGN_CHECK_EN`:
  - Store `0x7777` to `0x0031` -> `err = 1` with `data_valid`; load `0x0030` still returns prior value.
  - Load `0x0031` -> `rdata = 0000`, `err = 1`.
